// File: rtl/hdb3_rx_ctrl.sv
// Receive-side HDB3 line controller: sanitises symbols, checks coding rules,
// runs the LOS/ACQ/LOCK machine, flushes the decoder and times its valid strobe.
module hdb3_rx_ctrl #(
  parameter int LOS_ZEROS = 32,
  parameter int ACQ_MARKS = 16,
  parameter int ERR_WIN   = 256,
  parameter int ERR_MAX   = 8,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_hdb3_code,
  input  logic             i_cnt_clr,
  output logic [1:0]       o_hdb3_code,
  output logic             o_dec_rst_n,
  output logic             o_data_valid,
  output logic             o_los,
  output logic             o_lock,
  output logic             o_cv_pulse,
  output logic [CNT_W-1:0] o_cv_count
);

  localparam int ZR_W = $clog2(LOS_ZEROS + 1);
  localparam int MC_W = $clog2(ACQ_MARKS + 1);
  localparam int WC_W = $clog2(ERR_WIN);
  localparam int EC_W = $clog2(ERR_MAX + 1);

  localparam logic [1:0] ST_LOS  = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam logic [ZR_W-1:0]  ZR_SAT   = ZR_W'(LOS_ZEROS);
  localparam logic [ZR_W-1:0]  ZR_CV    = ZR_W'(4);
  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(ACQ_MARKS - 1);
  localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(ERR_WIN - 1);
  localparam logic [EC_W-1:0]  EC_MAX   = EC_W'(ERR_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic [ZR_W-1:0]  zero_run, zero_run_nxt;
  logic [MC_W-1:0]  mark_cnt, mark_cnt_nxt;
  logic [WC_W-1:0]  win_cnt, win_cnt_nxt;
  logic [EC_W-1:0]  win_cv, win_cv_nxt, win_cv_base;
  logic             last_mark_pol, last_mark_nxt;
  logic             last_v_pol, last_v_nxt;
  logic             dec_rst_nxt;
  logic [4:0]       dv_sr;

  logic is_mark, illegal, mark_pol, is_v, run_cv, run_lost, cv;

  always_comb begin
    is_mark      = i_hdb3_code[1] ^ i_hdb3_code[0];
    illegal      = &i_hdb3_code;
    mark_pol     = i_hdb3_code[1];
    is_v         = is_mark && (mark_pol == last_mark_pol);
    zero_run_nxt = is_mark ? '0 : ((zero_run == ZR_SAT) ? zero_run : zero_run + 1'b1);
    // the run is flagged on the step into 4 only, so long runs count once
    run_cv       = !is_mark && (zero_run_nxt == ZR_CV) && (zero_run != ZR_CV);
    run_lost     = (zero_run_nxt == ZR_SAT);
    cv           = (state != ST_LOS) &&
                   (illegal || run_cv || (is_v && (mark_pol == last_v_pol)));
  end

  always_comb begin
    state_nxt     = state;
    mark_cnt_nxt  = mark_cnt;
    win_cnt_nxt   = win_cnt;
    win_cv_nxt    = win_cv;
    dec_rst_nxt   = 1'b1;
    last_mark_nxt = is_mark ? mark_pol : last_mark_pol;
    last_v_nxt    = is_v ? mark_pol : last_v_pol;
    win_cv_base   = (win_cnt == WC_LAST) ? '0 : win_cv;
    case (state)
      ST_LOS: begin
        if (is_mark) begin
          state_nxt    = ST_ACQ;
          mark_cnt_nxt = MC_ONE;
          last_v_nxt   = ~mark_pol;
          dec_rst_nxt  = 1'b0;
        end
      end
      ST_ACQ: begin
        if (run_lost) begin
          state_nxt = ST_LOS;
        end else if (cv) begin
          mark_cnt_nxt = '0;
        end else if (is_mark) begin
          mark_cnt_nxt = mark_cnt + 1'b1;
          if (mark_cnt == MC_LAST) begin
            state_nxt   = ST_LOCK;
            win_cnt_nxt = '0;
            win_cv_nxt  = '0;
          end
        end
      end
      ST_LOCK: begin
        win_cnt_nxt = (win_cnt == WC_LAST) ? '0 : win_cnt + 1'b1;
        win_cv_nxt  = win_cv_base + {{(EC_W-1){1'b0}}, cv};
        if (run_lost) begin
          state_nxt = ST_LOS;
        end else if (win_cv_nxt == EC_MAX) begin
          state_nxt    = ST_ACQ;
          mark_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_LOS;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_LOS;
      zero_run      <= '0;
      mark_cnt      <= '0;
      win_cnt       <= '0;
      win_cv        <= '0;
      last_mark_pol <= 1'b0;
      last_v_pol    <= 1'b0;
      o_hdb3_code   <= 2'b00;
      o_dec_rst_n   <= 1'b0;
      o_cv_pulse    <= 1'b0;
      o_cv_count    <= '0;
      dv_sr         <= '0;
    end else begin
      state         <= state_nxt;
      zero_run      <= zero_run_nxt;
      mark_cnt      <= mark_cnt_nxt;
      win_cnt       <= win_cnt_nxt;
      win_cv        <= win_cv_nxt;
      last_mark_pol <= last_mark_nxt;
      last_v_pol    <= last_v_nxt;
      o_hdb3_code   <= illegal ? 2'b00 : i_hdb3_code;
      o_dec_rst_n   <= dec_rst_nxt;
      o_cv_pulse    <= cv;
      if (i_cnt_clr)
        o_cv_count <= cv ? CNT_ONE : '0;
      else if (cv && (o_cv_count != CNT_SAT))
        o_cv_count <= o_cv_count + 1'b1;
      // the lock flop lines up with o_hdb3_code, so five more stages meet the decoder bit
      if (!dec_rst_nxt || !o_dec_rst_n)
        dv_sr <= '0;
      else
        dv_sr <= {dv_sr[3:0], (state == ST_LOCK)};
    end
  end

  assign o_los        = (state == ST_LOS);
  assign o_lock       = (state == ST_LOCK);
  assign o_data_valid = dv_sr[4];

endmodule

// File: tb/tb_hdb3_rx_ctrl.sv
// Directed bench for hdb3_rx_ctrl: default-width instance plus a CNT_W=4 instance
// fed the same stimulus, checked with immediate assertions.
module tb_hdb3_rx_ctrl;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  code;
  logic        clr;

  logic [1:0]  hc16, hc4;
  logic        drn16, drn4, dv16, dv4, los16, los4, lock16, lock4, cvp16, cvp4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int dlow   = 0;

  always #5 clk = ~clk;

  hdb3_rx_ctrl dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdb3_code(code), .i_cnt_clr(clr),
    .o_hdb3_code(hc16), .o_dec_rst_n(drn16), .o_data_valid(dv16),
    .o_los(los16), .o_lock(lock16), .o_cv_pulse(cvp16), .o_cv_count(cnt16)
  );

  hdb3_rx_ctrl #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdb3_code(code), .i_cnt_clr(clr),
    .o_hdb3_code(hc4), .o_dec_rst_n(drn4), .o_data_valid(dv4),
    .o_los(los4), .o_lock(lock4), .o_cv_pulse(cvp4), .o_cv_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c);
    code = c;
    @(posedge clk);
    #1;
    pulses += int'(cvp16);
    if (!drn16) dlow++;
  endtask

  initial begin
    rst_n = 1'b0;
    code  = Z;
    clr   = 1'b0;
    #12;
    chk("rst_code",  {30'd0, hc16}, 0);
    chk("rst_decrst", {31'd0, drn16}, 0);
    chk("rst_valid", {31'd0, dv16}, 0);
    chk("rst_los",   {31'd0, los16}, 1);
    chk("rst_lock",  {31'd0, lock16}, 0);
    chk("rst_cvp",   {31'd0, cvp16}, 0);
    chk("rst_count", {16'd0, cnt16}, 0);
    rst_n = 1'b1;

    // idle line
    send(Z);
    chk("decrst_rise", {31'd0, drn16}, 1);
    for (int k = 0; k < 39; k++) send(Z);
    chk("idle_los",   {31'd0, los16}, 1);
    chk("idle_lock",  {31'd0, lock16}, 0);
    chk("idle_count", {16'd0, cnt16}, 0);

    // acquisition from alternating marks
    pulses = 0;
    dlow   = 0;
    send(P);
    chk("flush_low", {31'd0, drn16}, 0);
    chk("acq_los",   {31'd0, los16}, 0);
    chk("code_out",  {30'd0, hc16}, 2);
    send(M);
    chk("flush_one_cycle", {31'd0, drn16}, 1);
    for (int k = 3; k <= 16; k++) begin
      send((k % 2 == 1) ? P : M);
      if (k == 15) chk("lock_before_16", {31'd0, lock16}, 0);
    end
    chk("lock_at_16", {31'd0, lock16}, 1);
    send(P); send(M); send(P); send(M);
    chk("valid_lag4", {31'd0, dv16}, 0);
    send(P);
    chk("valid_lag5", {31'd0, dv16}, 1);
    chk("acq_no_cv", pulses, 0);
    chk("acq_flush_cnt", dlow, 1);

    // three distinct violations while locked
    pulses = 0;
    send(X);
    chk("cv_illegal",  {31'd0, cvp16}, 1);
    chk("illegal_san", {30'd0, hc16}, 0);
    send(M);
    for (int k = 1; k <= 5; k++) begin
      send(Z);
      if (k == 4) chk("cv_zero4", {31'd0, cvp16}, 1);
    end
    chk("zero5_once", {31'd0, cvp16}, 0);
    send(P); send(M); send(M);
    chk("cv_v_repeat", {31'd0, cvp16}, 1);
    send(P); send(P);
    chk("v_alt_ok", {31'd0, cvp16}, 0);
    chk("three_pulses", pulses, 3);
    chk("count3", {16'd0, cnt16}, 3);
    chk("lock_held", {31'd0, lock16}, 1);

    // clean traffic past a window wrap, then 8 violations in one window
    pulses = 0;
    for (int k = 0; k < 250; k++) send((k % 2 == 1) ? P : M);
    chk("wrap_lock", {31'd0, lock16}, 1);
    chk("wrap_no_cv", pulses, 0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      send(X);
      if (k == 7) chk("lock_at_7cv", {31'd0, lock16}, 1);
    end
    chk("drop_lock", {31'd0, lock16}, 0);
    chk("drop_los",  {31'd0, los16}, 0);
    chk("drop_count", {16'd0, cnt16}, 11);
    pulses = 0;
    dlow   = 0;
    for (int k = 1; k <= 16; k++) begin
      send((k % 2 == 1) ? M : P);
      if (k == 15) chk("relock_15", {31'd0, lock16}, 0);
    end
    chk("relock_16", {31'd0, lock16}, 1);
    chk("relock_noflush", dlow, 0);
    chk("relock_no_cv", pulses, 0);

    // loss of signal
    pulses = 0;
    for (int k = 0; k < 31; k++) send(Z);
    chk("los_31", {31'd0, los16}, 0);
    send(Z);
    chk("los_32", {31'd0, los16}, 1);
    chk("los_unlock", {31'd0, lock16}, 0);
    chk("los_cv_once", pulses, 1);
    chk("los_count", {16'd0, cnt16}, 12);
    repeat (4) send(Z);
    chk("los_valid_4", {31'd0, dv16}, 1);
    send(Z);
    chk("los_valid_5", {31'd0, dv16}, 0);
    send(P);
    chk("reacq_flush", {31'd0, drn16}, 0);
    chk("reacq_los",   {31'd0, los16}, 0);

    // counter clear and saturation
    clr = 1'b1;
    send(M);
    clr = 1'b0;
    chk("clr16", {16'd0, cnt16}, 0);
    chk("clr4",  {28'd0, cnt4}, 0);
    for (int k = 0; k < 20; k++) send(X);
    chk("sat4",    {28'd0, cnt4}, 15);
    chk("nosat16", {16'd0, cnt16}, 20);
    clr = 1'b1;
    send(X);
    clr = 1'b0;
    chk("clr_cv4",  {28'd0, cnt4}, 1);
    chk("clr_cv16", {16'd0, cnt16}, 1);

    // asynchronous reset mid-run
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_los",    {31'd0, los16}, 1);
    chk("arst_cvp",    {31'd0, cvp16}, 0);
    chk("arst_count",  {16'd0, cnt16}, 0);
    chk("arst_decrst", {31'd0, drn16}, 0);
    chk("arst_count4", {28'd0, cnt4}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
